// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MIPS memory stage: writeback pass-through plus req/ack data-memory loads and stores
module mem_lsu #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_wreg,
  input  logic [REG_ADDR_W-1:0] i_wreg_addr,
  input  logic [31:0]           i_wreg_data,
  input  logic                  i_whilo,
  input  logic [31:0]           i_hi,
  input  logic [31:0]           i_lo,
  input  logic [3:0]            i_mem_op,
  input  logic [ADDR_W-1:0]     i_mem_addr,
  input  logic [31:0]           i_mem_wdata,
  output logic                  o_stall,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [3:0]            dm_be,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_ack,
  input  logic [31:0]           dm_rdata,
  output logic                  o_valid,
  output logic                  o_wreg,
  output logic [REG_ADDR_W-1:0] o_wreg_addr,
  output logic [31:0]           o_wreg_data,
  output logic                  o_whilo,
  output logic [31:0]           o_hi,
  output logic [31:0]           o_lo,
  output logic                  o_addr_err,
  output logic                  o_bus_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] tcnt;
  logic [3:0]       op_q;
  logic [1:0]       lane_q;

  logic        is_load, is_store, is_mem, misaligned, timeout_hit, done;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load     = i_mem_op inside {[4'd1:4'd5]};
    is_store    = i_mem_op inside {[4'd6:4'd8]};
    is_mem      = is_load || is_store;
    misaligned  = ((i_mem_op == 4'd3 || i_mem_op == 4'd4 || i_mem_op == 4'd7) && i_mem_addr[0]) ||
                  ((i_mem_op == 4'd5 || i_mem_op == 4'd8) && (i_mem_addr[1:0] != 2'b00));
    timeout_hit = (TIMEOUT_CYC != 0) && (state == BUSY) && (tcnt == CNT_LAST) && !dm_ack;
    done        = (state == BUSY) && (dm_ack || timeout_hit);
    o_stall     = (state == IDLE) ? (i_valid && is_mem && !misaligned) : !(dm_ack || timeout_hit);
  end

  // Store data is replicated across lanes so memory only needs the byte enables.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = i_mem_wdata;
    case (i_mem_op)
      4'd6: begin
        st_be    = 4'b0001 << i_mem_addr[1:0];
        st_wdata = {4{i_mem_wdata[7:0]}};
      end
      4'd7: begin
        st_be    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dm_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      4'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      4'd2:    ld_data = {24'b0, ld_byte};
      4'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
      4'd4:    ld_data = {16'b0, ld_half};
      default: ld_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_be       <= '0;
      dm_wdata    <= '0;
      o_valid     <= 1'b0;
      o_wreg      <= 1'b0;
      o_wreg_addr <= '0;
      o_wreg_data <= '0;
      o_whilo     <= 1'b0;
      o_hi        <= '0;
      o_lo        <= '0;
      o_addr_err  <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_wreg     <= 1'b0;
      o_whilo    <= 1'b0;
      o_addr_err <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (is_mem && !misaligned) begin
              state    <= BUSY;
              tcnt     <= '0;
              dm_req   <= 1'b1;
              dm_we    <= is_store;
              dm_addr  <= {i_mem_addr[ADDR_W-1:2], 2'b00};
              dm_be    <= st_be;
              dm_wdata <= st_wdata;
              op_q     <= i_mem_op;
              lane_q   <= i_mem_addr[1:0];
            end else begin
              // A misaligned access retires immediately with no architectural writes.
              o_valid     <= 1'b1;
              o_wreg      <= i_wreg && !is_mem;
              o_whilo     <= i_whilo && !is_mem;
              o_addr_err  <= is_mem;
              o_wreg_addr <= i_wreg_addr;
              o_wreg_data <= i_wreg_data;
              o_hi        <= i_hi;
              o_lo        <= i_lo;
            end
          end
        end
        BUSY: begin
          if (done) begin
            state       <= IDLE;
            tcnt        <= '0;
            dm_req      <= 1'b0;
            o_valid     <= 1'b1;
            o_bus_err   <= timeout_hit;
            o_wreg      <= i_wreg && !dm_we && !timeout_hit;
            o_whilo     <= i_whilo && !timeout_hit;
            o_wreg_addr <= i_wreg_addr;
            o_wreg_data <= dm_we ? i_wreg_data : ld_data;
            o_hi        <= i_hi;
            o_lo        <= i_lo;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard bench for mem_lsu with randomized ops and a variable-latency memory model
module tb_mem_lsu;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_wreg = 1'b0, i_whilo = 1'b0;
  logic [4:0]  i_wreg_addr = '0;
  logic [31:0] i_wreg_data = '0, i_hi = '0, i_lo = '0, i_mem_addr = '0, i_mem_wdata = '0;
  logic [3:0]  i_mem_op = '0;
  logic        o_stall, dm_req, dm_we, dm_ack, o_valid, o_wreg, o_whilo, o_addr_err, o_bus_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, o_wreg_data, o_hi, o_lo;
  logic [3:0]  dm_be;
  logic [4:0]  o_wreg_addr;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_wreg(i_wreg), .i_wreg_addr(i_wreg_addr),
    .i_wreg_data(i_wreg_data), .i_whilo(i_whilo), .i_hi(i_hi), .i_lo(i_lo),
    .i_mem_op(i_mem_op), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .o_stall(o_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .o_valid(o_valid),
    .o_wreg(o_wreg), .o_wreg_addr(o_wreg_addr), .o_wreg_data(o_wreg_data),
    .o_whilo(o_whilo), .o_hi(o_hi), .o_lo(o_lo), .o_addr_err(o_addr_err), .o_bus_err(o_bus_err)
  );

  typedef struct {
    logic wreg; logic [4:0] waddr; logic [31:0] wdata;
    logic whilo; logic [31:0] hi; logic [31:0] lo; logic aerr; logic berr;
  } res_t;
  typedef struct {
    logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int d; logic [31:0] rdata;
  } req_t;

  res_t exp_q[$];
  req_t req_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic logic [31:0] load_model(int op, logic [31:0] addr, logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (addr[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      1: return b[7] ? (b | 32'hFFFF_FF00) : b;
      2: return b;
      3: return h[15] ? (h | 32'hFFFF_0000) : h;
      4: return h;
      default: return word;
    endcase
  endfunction

  // d = BUSY cycle on which memory acks; d >= T means no ack in time.
  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] wd,
                       input int d, input logic [31:0] rdata);
    res_t r;
    req_t q;
    bit   is_ld, is_st, mis, s;
    int   stalls, exp_st;
    i_valid = 1'b1; i_mem_op = op[3:0]; i_mem_addr = addr; i_mem_wdata = wd;
    i_wreg = 1'($urandom); i_wreg_addr = 5'($urandom); i_wreg_data = $urandom;
    i_whilo = 1'($urandom); i_hi = $urandom; i_lo = $urandom;
    is_ld = (op >= 1 && op <= 5);
    is_st = (op >= 6 && op <= 8);
    mis = ((op == 3 || op == 4 || op == 7) && (addr % 2 != 0)) ||
          ((op == 5 || op == 8) && (addr % 4 != 0));
    r = '{wreg: i_wreg, waddr: i_wreg_addr, wdata: i_wreg_data, whilo: i_whilo,
          hi: i_hi, lo: i_lo, aerr: 1'b0, berr: 1'b0};
    exp_st = 0;
    if (is_ld || is_st) begin
      if (mis) begin
        r.wreg = 1'b0; r.whilo = 1'b0; r.aerr = 1'b1;
      end else begin
        q.we = is_st; q.addr = addr & ~32'h3; q.d = d; q.rdata = rdata;
        q.be = 4'hF; q.wdata = wd;
        if (op == 6) begin
          q.be = 4'(1 << addr[1:0]); q.wdata = {24'b0, wd[7:0]} * 32'h0101_0101;
        end else if (op == 7) begin
          q.be = addr[1] ? 4'hC : 4'h3; q.wdata = {16'b0, wd[15:0]} * 32'h0001_0001;
        end
        req_q.push_back(q);
        exp_st = ((d < T) ? d : T - 1) + 1;
        if (d >= T) begin
          r.wreg = 1'b0; r.whilo = 1'b0; r.berr = 1'b1;
        end else if (is_st) r.wreg = 1'b0;
        else r.wdata = load_model(op, addr, rdata);
      end
    end
    exp_q.push_back(r);
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      s = o_stall;
      if (s) stalls++;
      @(posedge clk); #1;
      if (!s) break;
    end
    i_valid = 1'b0;
    check("stall_cycles", stalls, exp_st);
  endtask

  task automatic bubble();
    i_valid = 1'b0; i_mem_op = 4'($urandom); i_wreg = 1'($urandom); i_whilo = 1'($urandom);
    @(negedge clk);
    check("bubble_stall", o_stall, 0);
    @(posedge clk); #1;
  endtask

  // Memory responder: validates each request and acks after the scheduled delay.
  initial begin
    bit   in_txn;
    int   idx;
    req_t cur;
    in_txn = 0; idx = 0;
    dm_ack = 1'b0; dm_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dm_ack = 1'b0;
      dm_rdata = $urandom;
      if (in_txn && !dm_req) begin
        in_txn = 0;
        if (cur.d >= T) dm_ack = 1'b1;
      end else if (in_txn) begin
        idx++;
        check("dm_addr_hold", dm_addr, cur.addr);
      end else if (dm_req) begin
        if (req_q.size() == 0) check("unexpected_req", 1, 0);
        else begin
          cur = req_q.pop_front();
          in_txn = 1; idx = 0;
          check("dm_we", dm_we, cur.we);
          check("dm_addr", dm_addr, cur.addr);
          if (cur.we) begin
            check("dm_be", dm_be, cur.be);
            check("dm_wdata", dm_wdata, cur.wdata);
          end
        end
      end
      if (in_txn && cur.d < T && idx == cur.d) begin
        dm_ack = 1'b1;
        dm_rdata = cur.rdata;
      end
    end
  end

  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_valid) begin
          if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
          else begin
            r = exp_q.pop_front();
            check("o_wreg", o_wreg, r.wreg);
            check("o_whilo", o_whilo, r.whilo);
            check("o_addr_err", o_addr_err, r.aerr);
            check("o_bus_err", o_bus_err, r.berr);
            if (r.wreg) begin
              check("o_wreg_addr", o_wreg_addr, r.waddr);
              check("o_wreg_data", o_wreg_data, r.wdata);
            end
            if (r.whilo) begin
              check("o_hi", o_hi, r.hi);
              check("o_lo", o_lo, r.lo);
            end
          end
        end else begin
          check("quiet_outputs", {o_wreg, o_whilo, o_addr_err, o_bus_err}, 0);
        end
      end
    end
  end

  initial begin
    req_t q;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {o_stall, dm_req, dm_we, o_valid, o_wreg, o_whilo, o_addr_err, o_bus_err}, 0);
    check("reset_data", o_wreg_data | o_hi | o_lo | dm_addr | dm_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(0, 32'h0, 32'h0, 0, 32'h0);
    issue(1, 32'h1003, 32'h0, 2, 32'h80FF_0000);
    issue(2, 32'h1003, 32'h0, 2, 32'h80FF_0000);
    issue(7, 32'h2002, 32'h1234_ABCD, 0, 32'h0);
    issue(5, 32'h2001, 32'h0, 0, 32'h0);
    issue(0, 32'h0, 32'h0, 0, 32'h0);
    issue(8, 32'h40, 32'hCAFE_F00D, T + 2, 32'h0);
    issue(11, 32'h0, 32'h0, 0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) bubble();
      issue($urandom_range(0, 15), $urandom, $urandom, $urandom_range(0, T + 2), $urandom);
    end

    // Reset during the second BUSY cycle of a load that never gets acked.
    i_valid = 1'b1; i_mem_op = 4'd5; i_mem_addr = 32'h3000;
    q = '{we: 1'b0, addr: 32'h3000, be: 4'hF, wdata: 32'h0, d: T + 2, rdata: 32'h0};
    req_q.push_back(q);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("rst_busy_ctrl", {dm_req, o_valid, o_stall, o_bus_err}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("late_ack_ignored", {dm_req, o_valid, o_stall}, 0);

    repeat (4) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Registered memory stage for the 5-stage MIPS core, sitting between the EX/MEM pipeline register and MEM/WB. Passes register-file and HI/LO writeback results through a pipeline register. Executes byte, half and word loads and stores against a variable-latency data memory using a req/ack handshake. Stalls upstream while an access is in flight and flags misaligned addresses and bus timeouts.

Parameters:
ADDR_W, 32, data-memory byte-address width
REG_ADDR_W, 5, register-file address width
TIMEOUT_CYC, 16, maximum BUSY cycles without dm_ack before bus error (0 = timeout disabled)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_valid  in  1  instruction present on inputs
i_wreg  in  1  register write enable from EX
i_wreg_addr  in  REG_ADDR_W  destination register
i_wreg_data  in  32  ALU result (non-load)
i_whilo  in  1  HI/LO write enable
i_hi  in  32  HI value
i_lo  in  32  LO value
i_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9-15 treated as none
i_mem_addr  in  ADDR_W  effective byte address
i_mem_wdata  in  32  store data (rt)
o_stall  out  1  hold EX/MEM register and upstream stages
dm_req  out  1  memory request, registered
dm_we  out  1  1 = store
dm_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dm_be  out  4  byte enables, lane 0 = bits 7:0
dm_wdata  out  32  lane-replicated store data
dm_ack  in  1  access complete; dm_rdata valid this cycle for loads
dm_rdata  in  32  read word
o_valid  out  1  MEM/WB result valid
o_wreg  out  1  register write enable to WB
o_wreg_addr  out  REG_ADDR_W  destination register
o_wreg_data  out  32  writeback data
o_whilo  out  1  HI/LO write enable
o_hi  out  32  HI value
o_lo  out  32  LO value
o_addr_err  out  1  misaligned access, one-cycle pulse with o_valid
o_bus_err  out  1  timeout, one-cycle pulse with o_valid

Behaviour:
- Reset: clk and rst only; synchronous, active-high. All outputs 0, state IDLE, timeout counter 0. Reset in BUSY drops dm_req at that edge. A late dm_ack in IDLE is ignored.
- Alignment: misaligned when (LH/LHU/SH and addr[0]) or (LW/SW and addr[1:0]!=0). Byte ops are never misaligned.
- IDLE, i_valid, non-memory op: at the next edge, outputs take the inputs and o_valid=1. o_stall=0. Latency is 1 cycle.
- IDLE, i_valid, misaligned memory op: no request is issued. At the next edge, o_valid=1, o_addr_err=1, o_wreg=0, o_whilo=0. o_stall=0.
- IDLE, i_valid, aligned memory op: o_stall=1 (combinational). At the next edge, go to BUSY and drive dm_req=1, dm_we, dm_addr, dm_be and dm_wdata from the inputs. o_valid=0 in that cycle.
- BUSY: dm_req and all dm_* outputs are held stable until completion. Inputs are held by the stall. o_stall = !dm_ack && !timeout_hit.
- BUSY with dm_ack: o_stall=0 in the same cycle. At that edge:
  - dm_req=0 and the FSM returns to IDLE.
  - o_valid=1.
  - Loads: o_wreg=i_wreg, o_wreg_data = extracted dm_rdata.
  - Stores: o_wreg=0.
  - o_whilo, o_hi and o_lo pass from the inputs.
  - Minimum memory-op latency is 2 cycles.
- Timeout: the counter increments each BUSY cycle without ack. timeout_hit = (TIMEOUT_CYC!=0 and count==TIMEOUT_CYC-1 and !dm_ack). On timeout_hit, complete as with ack but with o_bus_err=1, o_wreg=0, o_whilo=0. The counter clears on leaving BUSY.
- Load extraction:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword at addr[1] (0 = bits 15:0), sign- or zero-extended.
  - LW: full word.
- Store enables:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- i_valid=0 in IDLE: o_valid=0, o_wreg=0, o_whilo=0 at the next edge. The data outputs hold their previous values.
- o_addr_err and o_bus_err are high for exactly one cycle per event.

Test Plan:
- ALU pass-through: i_wreg=1, addr 5'd3, data 32'hDEADBEEF, i_whilo=1, hi 32'h1, lo 32'h2 -> next cycle o_valid=1, o_wreg_data=DEADBEEF, o_hi=1, o_lo=2, no dm_req, o_stall never high.
- LB/LBU at addr 0x1003, dm_rdata=32'h80FF_0000, ack 3 cycles after req:
  - dm_addr=0x1000, dm_be=4'b1111 not required on loads (check dm_we=0).
  - o_stall is high exactly 3 cycles.
  - Result LB=32'hFFFFFF80, LBU=32'h00000080.
- SH at addr 0x2002, i_mem_wdata 32'h1234ABCD, ack after 1 cycle -> dm_be=4'b1100, dm_wdata=32'hABCDABCD, dm_we=1, o_wreg=0, completes 2 cycles after issue.
- LW at 0x2001 -> no dm_req, o_addr_err=1 for one cycle, o_wreg=0. A following ALU op completes normally the next cycle.
- TIMEOUT_CYC=4, no ack -> dm_req high 4 cycles, then drops. o_bus_err=1 for one cycle, o_stall falls the same cycle. A late ack has no effect.
- rst asserted in the 2nd BUSY cycle -> next edge dm_req=0, all outputs 0, FSM IDLE. An ack the cycle after is ignored.
